// File: rtl/trace_packetizer_if.sv
// Control, memory-read and UART-TX signals of the trace packetizer, bundled for port use.
// The packetizer takes the slave modport; whoever drives start/mem data/tx_ready takes master.
interface trace_packetizer_if;
    logic        start;
    logic [4:0]  sel;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_r_en;
    logic [15:0] mem_r_addr;
    logic [7:0]  mem_r_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport slave (
        input  start, sel, mem_r_data, tx_ready,
        output busy, done, err, mem_r_en, mem_r_addr, tx_data, tx_valid
    );

    modport master (
        output start, sel, mem_r_data, tx_ready,
        input  busy, done, err, mem_r_en, mem_r_addr, tx_data, tx_valid
    );
endinterface

// File: rtl/trace_packetizer.sv
// Frames one memory region into A5 5A SEL LEN_H LEN_L payload[LEN] CSUM for the UART TX path.
// The checksum is the XOR of SEL, both length bytes and every payload byte.
module trace_packetizer #(
    parameter int         SAMPLES   = 1024,
    parameter int         BLK_BYTES = 16,
    parameter int         PRM_BYTES = 4,
    parameter logic [7:0] SYNC0     = 8'hA5,
    parameter logic [7:0] SYNC1     = 8'h5A
) (
    input  logic               clk1,
    input  logic               c10_resetn,
    trace_packetizer_if.slave  bus
);

    localparam logic [15:0] LEN_TRACE = 16'(SAMPLES);
    localparam logic [15:0] LEN_BLK   = 16'(BLK_BYTES);
    localparam logic [15:0] LEN_PRM   = 16'(PRM_BYTES);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR0, S_HDR1, S_SEL, S_LENH, S_LENL,
        S_RDREQ, S_RDWAIT, S_PAY, S_CSUM, S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  sel_q, sel_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [7:0]  csum_q, csum_d;
    logic        err_q, err_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        xfer;

    // A zero length marks an illegal select.
    function automatic logic [15:0] len_of(input logic [4:0] s);
        case (s)
            5'b10000:                   return LEN_PRM;
            5'b01000:                   return LEN_TRACE;
            5'b00001, 5'b00010, 5'b00100: return LEN_BLK;
            default:                    return 16'd0;
        endcase
    endfunction

    assign xfer = tx_valid_q & bus.tx_ready;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        len_d      = len_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        err_d      = err_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sel_d  = bus.sel;
                    len_d  = len_of(bus.sel);
                    idx_d  = 16'd0;
                    csum_d = 8'd0;
                    err_d  = 1'b0;
                    if (len_of(bus.sel) != 16'd0) begin
                        state_d = S_HDR0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end
                end
            end
            // HDR0 spends its first cycle loading the byte register; later byte
            // states are entered with their byte already loaded.
            S_HDR0: begin
                if (!tx_valid_q) begin
                    tx_data_d  = SYNC0;
                    tx_valid_d = 1'b1;
                end else if (xfer) begin
                    tx_data_d = SYNC1;
                    state_d   = S_HDR1;
                end
            end
            S_HDR1: begin
                if (xfer) begin
                    tx_data_d = {3'b000, sel_q};
                    state_d   = S_SEL;
                end
            end
            S_SEL: begin
                if (xfer) begin
                    csum_d    = csum_q ^ tx_data_q;
                    tx_data_d = len_q[15:8];
                    state_d   = S_LENH;
                end
            end
            S_LENH: begin
                if (xfer) begin
                    csum_d    = csum_q ^ tx_data_q;
                    tx_data_d = len_q[7:0];
                    state_d   = S_LENL;
                end
            end
            S_LENL: begin
                if (xfer) begin
                    csum_d     = csum_q ^ tx_data_q;
                    tx_valid_d = 1'b0;
                    state_d    = S_RDREQ;
                end
            end
            S_RDREQ: begin
                state_d = S_RDWAIT;
            end
            S_RDWAIT: begin
                tx_data_d  = bus.mem_r_data;
                tx_valid_d = 1'b1;
                state_d    = S_PAY;
            end
            S_PAY: begin
                if (xfer) begin
                    csum_d = csum_q ^ tx_data_q;
                    idx_d  = idx_q + 16'd1;
                    if (idx_q == len_q - 16'd1) begin
                        // Fold the last payload byte in directly so CSUM needs no extra cycle.
                        tx_data_d = csum_q ^ tx_data_q;
                        state_d   = S_CSUM;
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = S_RDREQ;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk1 or negedge c10_resetn) begin
        if (!c10_resetn) begin
            state_q    <= S_IDLE;
            sel_q      <= 5'd0;
            len_q      <= 16'd0;
            idx_q      <= 16'd0;
            csum_q     <= 8'd0;
            err_q      <= 1'b0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            err_q      <= err_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign bus.busy       = (state_q != S_IDLE) && (state_q != S_FIN);
    assign bus.done       = (state_q == S_FIN);
    assign bus.err        = err_q;
    assign bus.mem_r_en   = (state_q == S_RDREQ);
    assign bus.mem_r_addr = (state_q == S_RDREQ) ? idx_q : 16'd0;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_valid   = tx_valid_q;

endmodule

// File: tb/tb_trace_packetizer.sv
// Bench for trace_packetizer: table of packet requests checked against a byte scoreboard,
// plus hand sequences for stall/ignored start and mid-packet reset.
module tb_trace_packetizer;

    logic clk1 = 1'b0;
    logic c10_resetn;
    always #5 clk1 = ~clk1;

    trace_packetizer_if bus();

    trace_packetizer dut (
        .clk1       (clk1),
        .c10_resetn (c10_resetn),
        .bus        (bus)
    );

    typedef struct {
        logic [4:0] sel;
        bit         bp;
        bit         exp_err;
        int         exp_len;
        logic [7:0] exp_csum;
    } vec_t;

    int         total = 0;
    int         bad = 0;
    int         cyc_n = 0;
    int         start_cyc = 0;
    logic [7:0] byte_q[$];
    logic [4:0] cur_sel = 5'd0;
    bit         bp_en = 1'b0;
    int         rx_cnt, rd_cnt, done_cnt, first_valid_cyc, done_cyc;
    logic [15:0] exp_addr;
    logic [7:0] last_byte;
    bit         prev_stall;
    logic [7:0] prev_data;

    // Memory image: params 11 22 33 44, trace = addr[7:0], blocks = addr[7:0]^5C.
    function automatic logic [7:0] mem_byte(input logic [4:0] s, input logic [15:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        if (s == 5'b10000) return 8'((lo + 8'd1) * 8'h11);
        else if (s == 5'b01000) return lo;
        else return lo ^ 8'h5C;
    endfunction

    always @(posedge clk1)
        if (bus.mem_r_en) bus.mem_r_data <= mem_byte(cur_sel, bus.mem_r_addr);

    function automatic logic [31:0] outs();
        return {3'b000, bus.busy, bus.done, bus.err, bus.mem_r_en, bus.mem_r_addr,
                bus.tx_data, bus.tx_valid};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [7:0] e;
        if (c10_resetn !== 1'b1) begin
            prev_stall = 1'b0;
            return;
        end
        if (prev_stall) check("tx_hold", {bus.tx_valid, bus.tx_data}, {1'b1, prev_data});
        prev_stall = bus.tx_valid && !bus.tx_ready;
        prev_data  = bus.tx_data;
        if (bus.tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc_n;
        if (bus.mem_r_en) begin
            check("rd_addr", bus.mem_r_addr, exp_addr);
            exp_addr++;
            rd_cnt++;
        end
        if (bus.tx_valid && bus.tx_ready) begin
            if (byte_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL tx_extra: got byte %0h expected no byte", bus.tx_data);
            end else begin
                e = byte_q.pop_front();
                check("tx_byte", bus.tx_data, e);
            end
            rx_cnt++;
            last_byte = bus.tx_data;
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
    endtask

    task automatic step();
        @(negedge clk1);
        monitor();
        @(posedge clk1);
        cyc_n++;
        #1;
        if (bp_en) bus.tx_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic push_packet(input logic [4:0] s, input int len);
        logic [7:0]  cs;
        logic [7:0]  b;
        logic [15:0] l;
        cs = 8'd0;
        l  = 16'(len);
        byte_q.push_back(8'hA5);
        byte_q.push_back(8'h5A);
        b = {3'b000, s};  byte_q.push_back(b); cs ^= b;
        b = l[15:8];      byte_q.push_back(b); cs ^= b;
        b = l[7:0];       byte_q.push_back(b); cs ^= b;
        for (int i = 0; i < len; i++) begin
            b = mem_byte(s, 16'(i));
            byte_q.push_back(b);
            cs ^= b;
        end
        byte_q.push_back(cs);
    endtask

    task automatic clear_stats();
        rx_cnt = 0; rd_cnt = 0; done_cnt = 0; exp_addr = 16'd0;
        first_valid_cyc = -1; done_cyc = -1;
    endtask

    task automatic launch(input logic [4:0] s, input int len, input bit valid);
        clear_stats();
        cur_sel = s;
        if (valid) push_packet(s, len);
        bus.sel   = s;
        bus.start = 1'b1;
        start_cyc = cyc_n;
        step();
        bus.start = 1'b0;
        bus.sel   = 5'd0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        if (done_cnt == 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
        end
        repeat (3) step();
    endtask

    task automatic run_vec(input vec_t v);
        bp_en = v.bp;
        bus.tx_ready = 1'b1;
        launch(v.sel, v.exp_len, !v.exp_err);
        check("busy_after_start", bus.busy, !v.exp_err);
        wait_done(20000);
        check("done_cnt", done_cnt, 1);
        check("err", bus.err, v.exp_err);
        check("rx_cnt", rx_cnt, v.exp_err ? 0 : v.exp_len + 6);
        check("rd_cnt", rd_cnt, v.exp_len);
        check("queue_empty", byte_q.size(), 0);
        if (!v.exp_err) begin
            check("csum", last_byte, v.exp_csum);
        end else begin
            check("err_done_lat", (done_cyc > start_cyc) && (done_cyc - start_cyc <= 2), 1);
        end
        if (!v.bp && !v.exp_err) begin
            check("first_valid_lat", first_valid_cyc - start_cyc, 2);
            check("done_lat", done_cyc - start_cyc, 8 + 3 * v.exp_len);
        end
        bp_en = 1'b0;
        bus.tx_ready = 1'b1;
    endtask

    vec_t tbl[8];
    vec_t key_vec;

    initial begin
        int n;
        tbl[0] = '{sel: 5'b10000, bp: 1'b0, exp_err: 1'b0, exp_len: 4,    exp_csum: 8'h50};
        tbl[1] = '{sel: 5'b01000, bp: 1'b1, exp_err: 1'b0, exp_len: 1024, exp_csum: 8'h0C};
        tbl[2] = '{sel: 5'b00011, bp: 1'b0, exp_err: 1'b1, exp_len: 0,    exp_csum: 8'h00};
        tbl[3] = '{sel: 5'b00001, bp: 1'b1, exp_err: 1'b0, exp_len: 16,   exp_csum: 8'h11};
        tbl[4] = '{sel: 5'b00000, bp: 1'b0, exp_err: 1'b1, exp_len: 0,    exp_csum: 8'h00};
        tbl[5] = '{sel: 5'b00010, bp: 1'b0, exp_err: 1'b0, exp_len: 16,   exp_csum: 8'h12};
        tbl[6] = '{sel: 5'b11000, bp: 1'b0, exp_err: 1'b1, exp_len: 0,    exp_csum: 8'h00};
        tbl[7] = '{sel: 5'b00100, bp: 1'b1, exp_err: 1'b0, exp_len: 16,   exp_csum: 8'h14};
        key_vec = '{sel: 5'b00001, bp: 1'b0, exp_err: 1'b0, exp_len: 16, exp_csum: 8'h11};

        c10_resetn   = 1'b0;
        bus.start    = 1'b0;
        bus.sel      = 5'd0;
        bus.tx_ready = 1'b1;
        prev_stall   = 1'b0;
        prev_data    = 8'd0;
        last_byte    = 8'd0;
        clear_stats();

        repeat (3) @(negedge clk1);
        check("reset_outputs", outs(), 32'd0);
        @(posedge clk1);
        #1 c10_resetn = 1'b1;
        @(negedge clk1);
        check("release_outputs", outs(), 32'd0);
        @(posedge clk1);
        #1;

        foreach (tbl[i]) begin
            run_vec(tbl[i]);
            $display("vector %0d sel=%b rx=%0d rd=%0d err=%0b last=%0h", i, tbl[i].sel,
                     rx_cnt, rd_cnt, bus.err, last_byte);
        end

        // Stalled first byte, with start pulses that must be ignored while busy.
        clear_stats();
        cur_sel = 5'b00001;
        push_packet(5'b00001, 16);
        bus.tx_ready = 1'b0;
        bus.sel      = 5'b00001;
        bus.start    = 1'b1;
        start_cyc    = cyc_n;
        step();
        bus.start = 1'b0;
        repeat (20) step();
        check("stall_hold", {bus.tx_valid, bus.tx_data}, {1'b1, 8'hA5});
        check("stall_rx", rx_cnt, 0);
        bus.sel   = 5'b10000;
        bus.start = 1'b1;
        step();
        bus.start    = 1'b0;
        bus.tx_ready = 1'b1;
        repeat (8) step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done(2000);
        repeat (20) step();
        check("ign_done_cnt", done_cnt, 1);
        check("ign_rx_cnt", rx_cnt, 22);
        check("ign_rd_cnt", rd_cnt, 16);
        check("ign_queue_empty", byte_q.size(), 0);
        check("ign_busy", bus.busy, 0);
        $display("ignored-start packet rx=%0d done=%0d", rx_cnt, done_cnt);

        // Reset while the fifth KEY payload byte is in flight.
        clear_stats();
        cur_sel = 5'b00001;
        push_packet(5'b00001, 16);
        bus.sel   = 5'b00001;
        bus.start = 1'b1;
        start_cyc = cyc_n;
        step();
        bus.start = 1'b0;
        n = 0;
        while (rx_cnt < 9 && n < 200) begin
            step();
            n++;
        end
        check("pre_reset_rx", rx_cnt, 9);
        c10_resetn = 1'b0;
        #1;
        check("rst_async", outs(), 32'd0);
        repeat (2) begin
            @(negedge clk1);
            check("rst_hold", outs(), 32'd0);
        end
        @(posedge clk1);
        #1 c10_resetn = 1'b1;
        byte_q.delete();
        prev_stall = 1'b0;
        repeat (4) begin
            step();
            check("post_reset", outs(), 32'd0);
        end
        check("post_reset_rx", rx_cnt, 9);
        run_vec(key_vec);
        $display("post-reset packet rx=%0d last=%0h", rx_cnt, last_byte);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
